// File: rtl/mmio_uart_tx.sv
// ---------------------------------------------------------------------------
// mmio_uart_tx
//
// Memory-mapped 8N1 UART transmitter. It sits on the CPU load/store port next
// to the data RAM. It decodes a 16-register-byte window at BASE_ADDR and
// returns registered read data one clock after the address, so its timing
// matches a synchronous RAM read. When the block is not addressed, the read
// data is zero, so the top level can OR it with the RAM output.
//
// Register map (addr[3:2]; addr[1:0] ignored):
//   0 TXDATA  : write pushes in[7:0] into the TX FIFO; reads 0
//   1 STATUS  : bit0 full, bit1 empty, bit2 serialiser active,
//               bit3 overflow (sticky, write 1 to clear), [11:8] FIFO count
//   2 DIVISOR : [15:0] clocks per bit, 0 behaves as 1
//   3 reserved: reads 0, writes ignored
//
// Ports:
//   clk   in   1   clock, all state changes on posedge
//   rst   in   1   asynchronous active-high reset
//   addr  in  16   CPU byte address
//   in    in  32   CPU store data
//   wen   in   1   CPU store strobe
//   out   out 32   registered read data (0 when not selected)
//   tx    out  1   serial line, idles high
//   busy  out  1   frame in flight or FIFO non-empty
// ---------------------------------------------------------------------------
module mmio_uart_tx #(
  parameter logic [15:0] BASE_ADDR    = 16'hFF00,
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned FIFO_DEPTH   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] addr,
  input  logic [31:0] in,
  input  logic        wen,
  output logic [31:0] out,
  output logic        tx,
  output logic        busy
);

  localparam int unsigned PTR_W     = $clog2(FIFO_DEPTH);
  localparam logic [3:0]  DEPTH_CNT = 4'(FIFO_DEPTH);
  localparam logic [15:0] DIV_RESET = 16'(CLKS_PER_BIT);

  localparam logic [1:0] REG_TXDATA  = 2'd0;
  localparam logic [1:0] REG_STATUS  = 2'd1;
  localparam logic [1:0] REG_DIVISOR = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } state_t;

  // -------------------------------------------------------------------------
  // Bus decode
  // -------------------------------------------------------------------------
  logic       sel;
  logic [1:0] reg_idx;
  logic       wr_txdata;
  logic       wr_status;
  logic       wr_divisor;

  assign sel        = (addr[15:4] == BASE_ADDR[15:4]);
  assign reg_idx    = addr[3:2];
  assign wr_txdata  = sel && wen && (reg_idx == REG_TXDATA);
  assign wr_status  = sel && wen && (reg_idx == REG_STATUS);
  assign wr_divisor = sel && wen && (reg_idx == REG_DIVISOR);

  // Byte lanes and address bits that the register map never looks at.
  logic unused_bits;
  assign unused_bits = ^{addr[1:0], in[31:16]};

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  state_t             state_q,    state_d;
  logic [3:0]         count_q,    count_d;
  logic [PTR_W-1:0]   wr_ptr_q,   wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q,   rd_ptr_d;
  logic               overflow_q, overflow_d;
  logic [15:0]        divisor_q,  divisor_d;
  logic [15:0]        bit_div_q,  bit_div_d;   // D latched at frame start
  logic [15:0]        tick_q,     tick_d;      // clocks elapsed in current bit
  logic [2:0]         idx_q,      idx_d;       // data bit index
  logic               tx_q,       tx_d;
  logic [31:0]        out_q,      out_d;

  // FIFO storage and its registered read port. The read register doubles as
  // the frame byte: it is loaded on the pop edge and stays stable for the
  // whole frame, since the next pop only happens at the end of the stop bit.
  logic [7:0]         fifo_mem [FIFO_DEPTH];
  logic [7:0]         frame_byte_q;

  // -------------------------------------------------------------------------
  // FIFO control
  // -------------------------------------------------------------------------
  logic        fifo_has;
  logic        fifo_full;
  logic        bit_done;
  logic        pop;
  logic        push_ok;
  logic [15:0] eff_div;

  assign fifo_has  = (count_q != 4'd0);
  assign fifo_full = (count_q == DEPTH_CNT);
  assign bit_done  = (tick_q == (bit_div_q - 16'd1));
  assign eff_div   = (divisor_q == 16'd0) ? 16'd1 : divisor_q;

  // The serialiser pops from IDLE, or at the last clock of a stop bit so the
  // next start bit follows with no idle gap.
  always_comb begin
    pop = 1'b0;
    case (state_q)
      ST_IDLE: pop = fifo_has;
      ST_STOP: pop = bit_done && fifo_has;
      default: pop = 1'b0;
    endcase
  end

  // A pop on the same edge frees a slot, so a push into a full FIFO is
  // still accepted in that case.
  assign push_ok = wr_txdata && (!fifo_full || pop);

  always_comb begin
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    case ({push_ok, pop})
      2'b10:   count_d = count_q + 4'd1;
      2'b01:   count_d = count_q - 4'd1;
      default: count_d = count_q;
    endcase
    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  // Overflow is sticky. A TXDATA and a STATUS write cannot coincide (single
  // address), so set and clear never race.
  always_comb begin
    overflow_d = overflow_q;
    if (wr_txdata && fifo_full && !pop) begin
      overflow_d = 1'b1;
    end else if (wr_status && in[3]) begin
      overflow_d = 1'b0;
    end
  end

  assign divisor_d = wr_divisor ? in[15:0] : divisor_q;

  // -------------------------------------------------------------------------
  // Serialiser FSM (next state and registered tx level)
  // -------------------------------------------------------------------------
  logic [2:0] idx_inc;
  assign idx_inc = idx_q + 3'd1;

  always_comb begin
    state_d   = state_q;
    tick_d    = tick_q + 16'd1;
    idx_d     = idx_q;
    tx_d      = tx_q;
    bit_div_d = bit_div_q;
    case (state_q)
      ST_IDLE: begin
        tx_d   = 1'b1;
        tick_d = 16'd0;
        if (pop) begin
          state_d   = ST_START;
          tx_d      = 1'b0;
          bit_div_d = eff_div;
        end
      end
      ST_START: begin
        if (bit_done) begin
          state_d = ST_DATA;
          tick_d  = 16'd0;
          idx_d   = 3'd0;
          tx_d    = frame_byte_q[0];
        end
      end
      ST_DATA: begin
        if (bit_done) begin
          tick_d = 16'd0;
          if (idx_q == 3'd7) begin
            state_d = ST_STOP;
            tx_d    = 1'b1;
          end else begin
            idx_d = idx_inc;
            tx_d  = frame_byte_q[idx_inc];
          end
        end
      end
      ST_STOP: begin
        if (bit_done) begin
          tick_d = 16'd0;
          if (pop) begin
            state_d   = ST_START;
            tx_d      = 1'b0;
            bit_div_d = eff_div;
          end else begin
            state_d = ST_IDLE;
            tx_d    = 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        tx_d    = 1'b1;
        tick_d  = 16'd0;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Read data: sampled from pre-edge state, so a read never sees a write
  // made on the same edge.
  // -------------------------------------------------------------------------
  logic [31:0] status_word;
  assign status_word = {20'd0, count_q, 4'd0, overflow_q,
                        (state_q != ST_IDLE), ~fifo_has, fifo_full};

  always_comb begin
    out_d = 32'd0;
    if (sel) begin
      case (reg_idx)
        REG_STATUS:  out_d = status_word;
        REG_DIVISOR: out_d = {16'd0, divisor_q};
        default:     out_d = 32'd0;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Flops
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      count_q    <= 4'd0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
      divisor_q  <= DIV_RESET;
      bit_div_q  <= 16'd1;
      tick_q     <= 16'd0;
      idx_q      <= 3'd0;
      tx_q       <= 1'b1;
      out_q      <= 32'd0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      overflow_q <= overflow_d;
      divisor_q  <= divisor_d;
      bit_div_q  <= bit_div_d;
      tick_q     <= tick_d;
      idx_q      <= idx_d;
      tx_q       <= tx_d;
      out_q      <= out_d;
    end
  end

  // Storage has no reset: contents are meaningless once the pointers clear.
  // When full with a simultaneous push and pop, both hit the same slot; the
  // registered read returns the old byte, which is the one being popped.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      fifo_mem[wr_ptr_q] <= in[7:0];
    end
    if (pop) begin
      frame_byte_q <= fifo_mem[rd_ptr_q];
    end
  end

  assign out  = out_q;
  assign tx   = tx_q;
  assign busy = (state_q != ST_IDLE) || fifo_has;

endmodule
